npu_ctrl: RTL and testbench
===========================

# npu_ctrl

Sequencer for the NPU offload path. It consumes the CPU's `npu_start_matrix_mul` / `npu_start_conv` requests and executes the operation over a single-outstanding memory master port. Supported operations are an N×N signed 64-bit matrix multiply and an N-output, KTAPS-tap 1-D convolution. It returns a one-cycle `npu_done` pulse, which releases the CPU's PC stall.

## Interface
Parameters:
- `N`, default 4: matrix dimension, and the convolution output length; must be ≥ 1.
- `KTAPS`, default 3: number of convolution kernel taps; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `npu_start_matrix_mul`  in  1  level request from CPU; held until done.
- `npu_start_conv`  in  1  level request from CPU; held until done.
- `npu_done`  out  1  one-cycle completion pulse, registered.
- `busy`  out  1  high in any state other than IDLE.
- `a_base`  in  64  byte base of A (matmul) or x (conv); sampled at start.
- `b_base`  in  64  byte base of B (matmul) or w (conv); sampled at start.
- `c_base`  in  64  byte base of C (matmul) or y (conv); sampled at start.
- `mem_req`  out  1  memory request valid.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr`  out  64  byte address.
- `mem_wdata`  out  64  write data.
- `mem_ready`  in  1  request accepted this cycle when `mem_req` is also high.
- `mem_rvalid`  in  1  read data valid; responses return in order, with at least one cycle after acceptance.
- `mem_rdata`  in  64  read data.

## Operation
- Elements are 64-bit, with a stride of 8 bytes, stored row-major.
  - Matmul: A[i][k] is at a_base+8(iN+k), B[k][j] at b_base+8(kN+j), and C[i][j] at c_base+8(iN+j).
  - Conv: x[i+t] is at a_base+8(i+t), w[t] at b_base+8t, and y[i] at c_base+8i, for i in 0..N-1 and t in 0..KTAPS-1.
- States are IDLE, RD_A, WT_A, RD_B, WT_B, WR, DONE.
- IDLE:
  - If `npu_start_matrix_mul` is high, latch the bases, set op = MM, clear i, j, k and acc, and go to RD_A.
  - Otherwise, if `npu_start_conv` is high, do the same with op = CONV.
  - Matmul wins when both requests are high.
  - Requests are sampled only in IDLE.
- RD_A: drive a read of the A or x element. Stay in RD_A until `mem_ready`, then go to WT_A.
- WT_A: on `mem_rvalid`, latch a_reg = `mem_rdata` and go to RD_B.
- RD_B: drive a read of the B or w element. Stay in RD_B until `mem_ready`, then go to WT_B.
- WT_B: on `mem_rvalid`, set acc = acc + low64(signed a_reg × signed `mem_rdata`).
  - If k is at its last value (N-1 for matmul, KTAPS-1 for conv), go to WR.
  - Otherwise increment k and go to RD_A.
- WR: write acc to the C or y element. Stay in WR until `mem_ready`, then advance the output index:
  - Matmul: j increments, wrapping to 0 and incrementing i.
  - Conv: i increments.
  - Clear acc and k. If the advanced index is past the last output, go to DONE; otherwise go to RD_A.
- DONE: assert `npu_done`, then go to IDLE.
- Arithmetic wraps modulo 2^64; there is no overflow flag.
- `mem_rvalid` is ignored outside WT_A and WT_B.
- `mem_addr`, `mem_we` and `mem_wdata` are held stable while `mem_req` is high and `mem_ready` is low.

## Timing
- Reset values: `npu_done`=0, `busy`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. All internal state is 0 and the state is IDLE.
- Asserting `rst_n` low mid-operation immediately aborts the operation. A read response still in flight arrives while the block is in IDLE and is ignored.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- With zero-wait memory (`mem_ready`=1 and `mem_rvalid` one cycle after acceptance):
  - Each product term takes 4 cycles and each write takes 1 cycle.
  - Matmul: from the first RD_A cycle to the DONE cycle inclusive is N²(4N+1)+1 cycles, which is 273 for N=4.
  - Conv: the same span is N(4·KTAPS+1)+1 cycles, which is 53 for N=4, KTAPS=3.
- `npu_done` is high for exactly one cycle, and the block is back in IDLE the cycle after.
  - The CPU drops its request combinationally in the done cycle.
  - A back-to-back NPU instruction is sampled in the IDLE cycle that follows.

## Configuration
- `NPU_CONV_EN` defined: convolution is executed as described above.
- `NPU_CONV_EN` undefined:
  - The conv datapath and its address generation are removed.
  - A conv-only request goes IDLE → DONE, so `npu_done` pulses the cycle after sampling.
  - No memory traffic is issued for that request.
  - Matmul behaviour is unchanged.

## Test plan
- Identity matmul, zero-wait: A=I, B=1..16 → C=1..16. `npu_done` is a single pulse exactly 273 cycles after the first RD_A cycle. Exactly 128 reads and 16 writes are issued.
- Signed wrap: A all −1 (0xFFFF_FFFF_FFFF_FFFF), B all 2 → every C element is −8. A second case with A=B=2^63 at [0][0] and 0 elsewhere → C[0][0] = 0.
- Conv: x=1..6, w=[1,2,3] → y=[14,20,26,32], with done at cycle 53. With `NPU_CONV_EN` undefined, the same request → done one cycle after sampling, with `mem_req` never high.
- Both requests held high together → matmul is executed, y memory is untouched, and exactly one done pulse is produced.
- Random `mem_ready` stalls and `mem_rvalid` delays of 1–5 cycles → results identical to the zero-wait run. Address, write enable and write data stay stable through every stall, and spurious `mem_rvalid` pulses in IDLE have no effect.
- `rst_n` pulsed low while in WT_B → all outputs are 0 asynchronously. After release, a fresh identity matmul completes correctly.

Source files
------------

// File: rtl/npu_ctrl.sv
// NPU offload sequencer: signed 64-bit NxN matmul and N-output KTAPS-tap 1-D conv over a
// single-outstanding memory port. Define NPU_CONV_EN to build the convolution path.
module npu_ctrl #(
    parameter int unsigned N     = 4,
    parameter int unsigned KTAPS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        npu_start_matrix_mul,
    input  logic        npu_start_conv,
    output logic        npu_done,
    output logic        busy,
    input  logic [63:0] a_base,
    input  logic [63:0] b_base,
    input  logic [63:0] c_base,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);

    localparam int unsigned DW   = 64;
    localparam int unsigned MAXD = (N > KTAPS) ? N : KTAPS;
    localparam int unsigned IW   = $clog2(MAXD + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_WT_A, S_RD_B, S_WT_B, S_WR, S_DONE
    } state_e;

    typedef enum logic {OP_MM, OP_CONV} op_e;

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [IW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DW-1:0]   acc_q, acc_d, a_reg_q, a_reg_d;
    logic [DW-1:0]   a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
    logic            req_q, req_d, we_q, we_d, done_q, done_d;
    logic [DW-1:0]   addr_q, addr_d, wdata_q, wdata_d;

    logic [IW-1:0]   k_last, i_adv, j_adv;
    logic [DW-1:0]   a_off, b_off, c_off;

    // Next-state and next-output logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        acc_d    = acc_q;
        a_reg_d  = a_reg_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        c_base_d = c_base_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        i_adv    = i_q;
        j_adv    = j_q;
        k_last   = (op_q == OP_CONV) ? IW'(KTAPS - 1) : IW'(N - 1);

        unique case (state_q)
            S_IDLE: begin
                if (npu_start_matrix_mul || npu_start_conv) begin
                    a_base_d = a_base;
                    b_base_d = b_base;
                    c_base_d = c_base;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    acc_d    = '0;
                    state_d  = S_RD_A;
                    op_d     = npu_start_matrix_mul ? OP_MM : OP_CONV;
`ifndef NPU_CONV_EN
                    if (!npu_start_matrix_mul) begin
                        op_d    = OP_MM;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_RD_A: if (mem_ready) state_d = S_WT_A;
            S_WT_A: begin
                if (mem_rvalid) begin
                    a_reg_d = mem_rdata;
                    state_d = S_RD_B;
                end
            end
            S_RD_B: if (mem_ready) state_d = S_WT_B;
            S_WT_B: begin
                if (mem_rvalid) begin
                    // Low 64 bits of the product are identical for signed and unsigned operands.
                    acc_d = acc_q + DW'(a_reg_q * mem_rdata);
                    if (k_q == k_last) begin
                        state_d = S_WR;
                    end else begin
                        k_d     = k_q + IW'(1);
                        state_d = S_RD_A;
                    end
                end
            end
            S_WR: begin
                if (mem_ready) begin
                    if (op_q == OP_CONV) begin
                        i_adv = i_q + IW'(1);
                    end else if (j_q == IW'(N - 1)) begin
                        j_adv = '0;
                        i_adv = i_q + IW'(1);
                    end else begin
                        j_adv = j_q + IW'(1);
                    end
                    i_d     = i_adv;
                    j_d     = j_adv;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = (i_adv == IW'(N)) ? S_DONE : S_RD_A;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Element offsets for the upcoming access, in elements.
        a_off = DW'(i_d) * DW'(N) + DW'(k_d);
        b_off = DW'(k_d) * DW'(N) + DW'(j_d);
        c_off = DW'(i_d) * DW'(N) + DW'(j_d);
`ifdef NPU_CONV_EN
        if (op_d == OP_CONV) begin
            a_off = DW'(i_d) + DW'(k_d);
            b_off = DW'(k_d);
            c_off = DW'(i_d);
        end
`endif

        req_d  = (state_d == S_RD_A) || (state_d == S_RD_B) || (state_d == S_WR);
        we_d   = (state_d == S_WR);
        done_d = (state_d == S_DONE);
        unique case (state_d)
            S_RD_A:  addr_d = a_base_d + (a_off << 3);
            S_RD_B:  addr_d = b_base_d + (b_off << 3);
            S_WR:    addr_d = c_base_d + (c_off << 3);
            default: addr_d = addr_q;
        endcase
        if (state_d == S_WR) wdata_d = acc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MM;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            a_reg_q  <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            c_base_q <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            a_reg_q  <= a_reg_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            c_base_q <= c_base_d;
            req_q    <= req_d;
            we_q     <= we_d;
            done_q   <= done_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign npu_done  = done_q;
    assign busy      = (state_q != S_IDLE);
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_npu_ctrl.sv
// Self-checking bench for npu_ctrl: word-addressed memory responder with random stalls,
// transaction-order reference model, and literal checks on known results.
module tb_npu_ctrl;

    localparam int unsigned N      = 4;
    localparam int unsigned KTAPS  = 3;
    localparam int          BUDGET = 20000;
`ifdef NPU_CONV_EN
    localparam bit CONV_EN = 1'b1;
`else
    localparam bit CONV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_mm, start_cv;
    logic        npu_done, busy;
    logic [63:0] a_base, b_base, c_base;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    npu_ctrl #(.N(N), .KTAPS(KTAPS)) dut (
        .clk(clk), .rst_n(rst_n),
        .npu_start_matrix_mul(start_mm), .npu_start_conv(start_cv),
        .npu_done(npu_done), .busy(busy),
        .a_base(a_base), .b_base(b_base), .c_base(c_base),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [63:0] addr;
        logic [63:0] data;
    } txn_t;

    int          vectors = 0;
    int          errors  = 0;
    logic [63:0] mem [logic [63:0]];
    txn_t        exp_q [$];
    int          exp_rd, exp_wr;
    bit          zero_wait = 1'b1;
    int          rd_cnt = 0, wr_cnt = 0;

    localparam logic [63:0] AB = 64'h1000, BB = 64'h2000, CB = 64'h3000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rd_mem(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 64'd0;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Memory responder: settles requests accepted at the previous edge and drives ready/rvalid.
    bit          p_req = 0, p_ready = 0, p_we = 0, p_rst = 0;
    logic [63:0] p_addr = '0, p_wdata = '0;
    bit          pend = 0;
    int          pend_cnt = 0;
    logic [63:0] pend_data = '0;

    always begin
        @(posedge clk);
        #1;
        if (p_req && p_ready && p_rst && rst_n) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_txn: got we=%0b addr=%h, expected none", p_we, p_addr);
            end else begin
                txn_t e;
                e = exp_q.pop_front();
                check("txn_we", 64'(p_we), 64'(e.we));
                check("txn_addr", p_addr, e.addr);
                if (e.we) check("txn_wdata", p_wdata, e.data);
            end
            if (p_we) begin
                mem[p_addr] = p_wdata;
                wr_cnt++;
            end else begin
                rd_cnt++;
                pend      = 1'b1;
                pend_data = rd_mem(p_addr);
                pend_cnt  = zero_wait ? 1 : int'($urandom_range(1, 5));
            end
        end
        if (p_req && !p_ready && p_rst && rst_n) begin
            check("stall_req", 64'(mem_req), 64'd1);
            check("stall_we", 64'(mem_we), 64'(p_we));
            check("stall_addr", mem_addr, p_addr);
            check("stall_wdata", mem_wdata, p_wdata);
        end
        mem_rvalid = 1'b0;
        mem_rdata  = rnd64();
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_data;
                pend       = 1'b0;
            end
        end else if (!zero_wait && !busy && $urandom_range(0, 3) == 0) begin
            mem_rvalid = 1'b1;
        end
        mem_ready = zero_wait ? 1'b1 : ($urandom_range(0, 2) != 0);
        p_req   = mem_req;
        p_ready = mem_ready;
        p_we    = mem_we;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
        p_rst   = rst_n;
    end

    // Expected transaction stream straight from the operation definitions.
    task automatic build_model(input bit mm, input bit cv,
                               input logic [63:0] ab, input logic [63:0] bb, input logic [63:0] cb);
        logic [63:0] acc, av, bv, aa, ba, ca;
        exp_q.delete();
        exp_rd = 0;
        exp_wr = 0;
        if (mm) begin
            for (int i = 0; i < int'(N); i++)
                for (int j = 0; j < int'(N); j++) begin
                    acc = 64'd0;
                    for (int k = 0; k < int'(N); k++) begin
                        aa = ab + 64'(8 * (i * int'(N) + k));
                        ba = bb + 64'(8 * (k * int'(N) + j));
                        av = rd_mem(aa);
                        bv = rd_mem(ba);
                        acc = acc + av * bv;
                        exp_q.push_back('{1'b0, aa, 64'd0});
                        exp_q.push_back('{1'b0, ba, 64'd0});
                        exp_rd += 2;
                    end
                    ca = cb + 64'(8 * (i * int'(N) + j));
                    exp_q.push_back('{1'b1, ca, acc});
                    exp_wr++;
                end
        end else if (cv && CONV_EN) begin
            for (int i = 0; i < int'(N); i++) begin
                acc = 64'd0;
                for (int t = 0; t < int'(KTAPS); t++) begin
                    aa = ab + 64'(8 * (i + t));
                    ba = bb + 64'(8 * t);
                    acc = acc + rd_mem(aa) * rd_mem(ba);
                    exp_q.push_back('{1'b0, aa, 64'd0});
                    exp_q.push_back('{1'b0, ba, 64'd0});
                    exp_rd += 2;
                end
                exp_q.push_back('{1'b1, cb + 64'(8 * i), acc});
                exp_wr++;
            end
        end
    endtask

    // Issue one request and follow it to completion; span is checked only with zero-wait memory.
    task automatic run_op(input bit mm, input bit cv, input bit zw, input int exp_span,
                          input logic [63:0] ab, input logic [63:0] bb, input logic [63:0] cb);
        int tick, done_tick, req_seen;
        build_model(mm, cv, ab, bb, cb);
        @(posedge clk);
        #2;
        zero_wait = zw;
        rd_cnt    = 0;
        wr_cnt    = 0;
        a_base    = ab;
        b_base    = bb;
        c_base    = cb;
        start_mm  = mm;
        start_cv  = cv;
        tick      = 0;
        done_tick = 0;
        req_seen  = 0;
        while (done_tick == 0 && tick < BUDGET) begin
            @(posedge clk);
            #2;
            tick++;
            if (mem_req) req_seen++;
            if (npu_done) begin
                done_tick = tick;
                start_mm  = 1'b0;
                start_cv  = 1'b0;
            end
        end
        if (done_tick == 0) begin
            vectors++;
            errors++;
            $display("FAIL done_timeout: got no done in %0d cycles, expected a pulse", BUDGET);
            start_mm = 1'b0;
            start_cv = 1'b0;
        end
        if (zw) check("done_span", 64'(done_tick), 64'(exp_span));
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #2;
            if (n == 0) check("idle_after_done", 64'(busy), 64'd0);
            check("single_done", 64'(npu_done), 64'd0);
        end
        check("txn_left", 64'(exp_q.size()), 64'd0);
        check("reads", 64'(rd_cnt), 64'(exp_rd));
        check("writes", 64'(wr_cnt), 64'(exp_wr));
        if (exp_rd + exp_wr == 0) check("no_req", 64'(req_seen), 64'd0);
    endtask

    task automatic init_identity();
        mem.delete();
        for (int i = 0; i < int'(N); i++)
            for (int k = 0; k < int'(N); k++) begin
                mem[AB + 64'(8 * (i * int'(N) + k))] = (i == k) ? 64'd1 : 64'd0;
                mem[BB + 64'(8 * (i * int'(N) + k))] = 64'(i * int'(N) + k + 1);
            end
    endtask

    task automatic fill_ab(input logic [63:0] ab, input logic [63:0] bb, input logic [63:0] av,
                           input logic [63:0] bv, input bit rnd);
        mem.delete();
        for (int e = 0; e < int'(N * N); e++) begin
            mem[ab + 64'(8 * e)] = rnd ? rnd64() : av;
            mem[bb + 64'(8 * e)] = rnd ? rnd64() : bv;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] ra, rb, rc;
        logic [63:0] saved [N*N];
        int t;
        rst_n = 1'b0;
        start_mm = 1'b0;
        start_cv = 1'b0;
        a_base = '0;
        b_base = '0;
        c_base = '0;
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        #12;
        check("rst_done", 64'(npu_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req", 64'(mem_req), 64'd0);
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_addr", mem_addr, 64'd0);
        check("rst_wdata", mem_wdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        init_identity();
        run_op(1, 0, 1, 273, AB, BB, CB);
        check("id_reads", 64'(rd_cnt), 64'd128);
        check("id_writes", 64'(wr_cnt), 64'd16);
        for (int e = 0; e < 16; e++) check("id_C", rd_mem(CB + 64'(8 * e)), 64'(e + 1));

        fill_ab(AB, BB, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0);
        run_op(1, 0, 1, 273, AB, BB, CB);
        for (int e = 0; e < 16; e++) check("neg_C", rd_mem(CB + 64'(8 * e)), 64'hFFFF_FFFF_FFFF_FFF8);

        fill_ab(AB, BB, 64'd0, 64'd0, 1'b0);
        mem[AB] = 64'h8000_0000_0000_0000;
        mem[BB] = 64'h8000_0000_0000_0000;
        mem[CB] = 64'h5555;
        run_op(1, 0, 1, 273, AB, BB, CB);
        check("wrap_C00", rd_mem(CB), 64'd0);

        mem.delete();
        for (int e = 0; e < 6; e++) mem[AB + 64'(8 * e)] = 64'(e + 1);
        for (int e = 0; e < 3; e++) mem[BB + 64'(8 * e)] = 64'(e + 1);
        run_op(0, 1, 1, CONV_EN ? 53 : 1, AB, BB, CB);
        if (CONV_EN) begin
            check("conv_y0", rd_mem(CB), 64'd14);
            check("conv_y1", rd_mem(CB + 64'd8), 64'd20);
            check("conv_y2", rd_mem(CB + 64'd16), 64'd26);
            check("conv_y3", rd_mem(CB + 64'd24), 64'd32);
        end

        init_identity();
        run_op(1, 1, 1, 273, AB, BB, CB);
        check("both_C15", rd_mem(CB + 64'd120), 64'd16);

        for (int r = 0; r < 3; r++) begin
            ra = 64'h1_0000 + 64'(8 * $urandom_range(0, 255));
            rb = 64'h2_0000 + 64'(8 * $urandom_range(0, 255));
            rc = 64'h3_0000 + 64'(8 * $urandom_range(0, 255));
            fill_ab(ra, rb, 64'd0, 64'd0, 1'b1);
            run_op(1, 0, 0, 0, ra, rb, rc);
            for (int e = 0; e < int'(N * N); e++) saved[e] = rd_mem(rc + 64'(8 * e));
            run_op(1, 0, 1, 273, ra, rb, rc);
            for (int e = 0; e < int'(N * N); e++) check("stall_vs_zw", rd_mem(rc + 64'(8 * e)), saved[e]);
            run_op(0, 1, 0, 0, ra, rb, rc);
            run_op(r[0], 1, 0, 0, ra, rb, rc);
        end

        init_identity();
        build_model(1, 0, AB, BB, CB);
        @(posedge clk);
        #2;
        zero_wait = 1'b0;
        rd_cnt = 0;
        a_base = AB;
        b_base = BB;
        c_base = CB;
        start_mm = 1'b1;
        t = 0;
        while (rd_cnt < 2 && t < BUDGET) begin
            @(posedge clk);
            #2;
            t++;
        end
        check("reach_wt_b", 64'(rd_cnt), 64'd2);
        rst_n = 1'b0;
        #1;
        check("arst_done", 64'(npu_done), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_req", 64'(mem_req), 64'd0);
        check("arst_we", 64'(mem_we), 64'd0);
        check("arst_addr", mem_addr, 64'd0);
        check("arst_wdata", mem_wdata, 64'd0);
        start_mm = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        init_identity();
        run_op(1, 0, 1, 273, AB, BB, CB);
        for (int e = 0; e < 16; e++) check("post_rst_C", rd_mem(CB + 64'(8 * e)), 64'(e + 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
